// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: drives every stage enable and bubble in the core.
// Optional divider watchdog enabled by defining HZ_DIV_TIMEOUT_EN.
module hazard_stall_ctrl #(
    parameter int unsigned DIV_MAX_CYCLES = 40
) (
    input  logic        HZ_clk,
    input  logic        HZ_rst_n,
    input  logic        rs1_valid_D,
    input  logic        rs2_valid_D,
    input  logic [4:0]  reg_read_addr_1_D,
    input  logic [4:0]  reg_read_addr_2_D,
    input  logic [4:0]  reg_write_dest_E,
    input  logic        ld_E,
    input  logic        gprs_we_i_E,
    input  logic        PCnew_E,
    input  logic        Div_en_E,
    input  logic        ebreak_E,
    input  logic        div_done,
    input  logic        resume,
    output logic        PC_ce,
    output logic        IF_ID_ce,
    output logic        ID_EX_ce,
    output logic        EX_MEM_ce,
    output logic        IF_ID_nop,
    output logic        ID_EX_nop,
    output logic        div_start,
    output logic        halted,
    output logic [15:0] stall_cnt
`ifdef HZ_DIV_TIMEOUT_EN
    ,
    output logic        div_timeout
`endif
);

    typedef enum logic [1:0] {StRun, StDivBusy, StHalt} state_e;

    state_e      state_q, state_d;
    logic        skip_ebreak_q, skip_ebreak_d;
    logic [15:0] stall_cnt_q;
    logic        lu;
    logic        div_tmo;
    logic        div_release;
    logic        eval_tail;

    assign lu = ld_E & gprs_we_i_E & (reg_write_dest_E != 5'd0) &
                ((rs1_valid_D & (reg_read_addr_1_D == reg_write_dest_E)) |
                 (rs2_valid_D & (reg_read_addr_2_D == reg_write_dest_E)));

    assign div_release = div_done | div_tmo;

    // Ignore the EBREAK still sitting in EX for the one cycle after resume.
    assign skip_ebreak_d = (state_q == StHalt) & resume;

    always_comb begin
        state_d   = state_q;
        PC_ce     = 1'b0;
        IF_ID_ce  = 1'b0;
        ID_EX_ce  = 1'b0;
        EX_MEM_ce = 1'b0;
        IF_ID_nop = 1'b0;
        ID_EX_nop = 1'b0;
        div_start = 1'b0;
        halted    = 1'b0;
        eval_tail = 1'b0;

        unique case (state_q)
            StRun: begin
                if (ebreak_E && !skip_ebreak_q) begin
                    state_d = StHalt;
                end else if (!PCnew_E && Div_en_E) begin
                    div_start = 1'b1;
                    state_d   = StDivBusy;
                end else begin
                    eval_tail = 1'b1;
                end
            end
            StDivBusy: begin
                if (div_release) begin
                    eval_tail = 1'b1;
                    state_d   = StRun;
                end
            end
            StHalt: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        // Flush, load-use bubble or free run; shared by RUN and divide release.
        if (eval_tail) begin
            if (PCnew_E) begin
                {PC_ce, IF_ID_ce, ID_EX_ce, EX_MEM_ce} = 4'b1111;
                IF_ID_nop = 1'b1;
                ID_EX_nop = 1'b1;
            end else if (lu) begin
                ID_EX_ce  = 1'b1;
                ID_EX_nop = 1'b1;
                EX_MEM_ce = 1'b1;
            end else begin
                {PC_ce, IF_ID_ce, ID_EX_ce, EX_MEM_ce} = 4'b1111;
            end
        end

        if (!HZ_rst_n) begin
            {PC_ce, IF_ID_ce, ID_EX_ce, EX_MEM_ce} = 4'b0000;
            IF_ID_nop = 1'b0;
            ID_EX_nop = 1'b0;
            div_start = 1'b0;
            halted    = 1'b0;
        end
    end

    always_ff @(posedge HZ_clk or negedge HZ_rst_n) begin
        if (!HZ_rst_n) begin
            state_q       <= StRun;
            skip_ebreak_q <= 1'b0;
            stall_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            skip_ebreak_q <= skip_ebreak_d;
            if (!PC_ce && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef HZ_DIV_TIMEOUT_EN
    logic [15:0] div_cnt_q;
    logic        div_timeout_q;

    assign div_tmo = (state_q == StDivBusy) && (div_cnt_q == 16'(DIV_MAX_CYCLES));

    always_ff @(posedge HZ_clk or negedge HZ_rst_n) begin
        if (!HZ_rst_n) begin
            div_cnt_q     <= 16'd0;
            div_timeout_q <= 1'b0;
        end else begin
            if (state_q == StDivBusy && !div_release) begin
                div_cnt_q <= div_cnt_q + 16'd1;
            end else begin
                div_cnt_q <= 16'd0;
            end
            if (div_tmo && !div_done) begin
                div_timeout_q <= 1'b1;
            end
        end
    end

    assign div_timeout = div_timeout_q;
`else
    logic unused_div_max;
    assign div_tmo        = 1'b0;
    assign unused_div_max = ^DIV_MAX_CYCLES;
`endif

endmodule
